// File: rtl/minigame_hub_if.sv
// rtl/minigame_hub_if.sv - bundle of per-game core signals between the hub and its minigame cores
interface minigame_hub_if #(
  parameter int N_GAMES = 3,
  parameter int SCORE_W = 3,
  parameter int LED_W   = 3
);
  logic [4*N_GAMES-1:0]       game_estado;
  logic [7*N_GAMES-1:0]       game_jogada;
  logic [LED_W*N_GAMES-1:0]   game_leds;
  logic [SCORE_W*N_GAMES-1:0] game_pontuacao;
  logic [N_GAMES-1:0]         game_pronto;
  logic [N_GAMES-1:0]         game_jogar;
  logic                       game_dificuldade;

  modport master (
    output game_jogar, game_dificuldade,
    input  game_estado, game_jogada, game_leds, game_pontuacao, game_pronto
  );

  modport slave (
    input  game_jogar, game_dificuldade,
    output game_estado, game_jogada, game_leds, game_pontuacao, game_pronto
  );
endinterface

// File: rtl/minigame_hub.sv
// rtl/minigame_hub.sv - session dispatcher for N_GAMES minigame cores with best-score tracking
module minigame_hub #(
  parameter int N_GAMES     = 3,
  parameter int SEL_W       = 2,
  parameter int SCORE_W     = 3,
  parameter int LED_W       = 3,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               abortar,
  input  logic               dificuldade,
  input  logic [SEL_W-1:0]   minigame_sel,
  minigame_hub_if.master     games,
  output logic [SEL_W-1:0]   minigame_out,
  output logic [3:0]         estado_out,
  output logic [6:0]         jogada_out,
  output logic [LED_W-1:0]   leds_out,
  output logic [SCORE_W-1:0] pontuacao_out,
  output logic [SCORE_W-1:0] recorde_out,
  output logic               novo_recorde,
  output logic               timeout_out,
  output logic [2:0]         hub_estado
);

  typedef enum logic [2:0] {
    INICIAL    = 3'd0,
    PREPARACAO = 3'd1,
    EXECUCAO   = 3'd2,
    FIM        = 3'd3,
    ERRO       = 3'd4
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [SEL_W:0]   N_LIM    = (SEL_W+1)'(N_GAMES);

  state_t                     state, state_nx;
  logic                       iniciar_q;
  logic [SEL_W-1:0]           sel_q;
  logic                       dif_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [SCORE_W-1:0]         pont_q;
  logic [SCORE_W*N_GAMES-1:0] recorde_q;
  logic [N_GAMES-1:0]         jogar_q;
  logic                       novo_q;
  logic                       tmo_q;

  logic                       start_ev, sel_in_ok, sel_q_ok, pronto_sel, timeout_hit;
  logic [SEL_W-1:0]           idx;
  logic [SCORE_W-1:0]         score_sel, best_sel;

  assign start_ev    = iniciar & ~iniciar_q;
  assign sel_in_ok   = {1'b0, minigame_sel} < N_LIM;
  assign sel_q_ok    = {1'b0, sel_q} < N_LIM;
  // Out-of-range latched selections (ERRO) are steered to game 0 so no select ever leaves the bus.
  assign idx         = sel_q_ok ? sel_q : '0;
  assign pronto_sel  = games.game_pronto[idx];
  assign score_sel   = games.game_pontuacao[SCORE_W*idx +: SCORE_W];
  assign best_sel    = recorde_q[SCORE_W*idx +: SCORE_W];
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= INICIAL;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INICIAL:    if (start_ev) state_nx = PREPARACAO;
      PREPARACAO: state_nx = sel_in_ok ? EXECUCAO : ERRO;
      EXECUCAO: begin
        if (abortar)          state_nx = INICIAL;
        else if (pronto_sel)  state_nx = FIM;
        else if (timeout_hit) state_nx = FIM;
      end
      FIM:        if (start_ev) state_nx = PREPARACAO;
      ERRO:       if (start_ev) state_nx = PREPARACAO;
      default:    state_nx = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      iniciar_q <= 1'b0;
      sel_q     <= '0;
      dif_q     <= 1'b0;
      cnt_q     <= '0;
      pont_q    <= '0;
      recorde_q <= '0;
      jogar_q   <= '0;
      novo_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      iniciar_q <= iniciar;
      jogar_q   <= '0;
      case (state)
        PREPARACAO: begin
          sel_q  <= minigame_sel;
          dif_q  <= dificuldade;
          cnt_q  <= '0;
          pont_q <= '0;
          novo_q <= 1'b0;
          tmo_q  <= 1'b0;
          if (sel_in_ok) jogar_q <= N_GAMES'(1) << minigame_sel;
        end
        EXECUCAO: begin
          cnt_q <= cnt_q + 1'b1;
          if (abortar) begin
            novo_q <= 1'b0;
            tmo_q  <= 1'b0;
          end else if (pronto_sel) begin
            pont_q <= score_sel;
            novo_q <= score_sel > best_sel;
            if (score_sel > best_sel) recorde_q[SCORE_W*idx +: SCORE_W] <= score_sel;
          end else if (timeout_hit) begin
            tmo_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign games.game_jogar       = jogar_q;
  assign games.game_dificuldade = dif_q;
  assign minigame_out           = sel_q;
  assign hub_estado             = state;
  assign novo_recorde           = novo_q;
  assign timeout_out            = tmo_q;
  assign recorde_out            = sel_q_ok ? best_sel : '0;

  always_comb begin
    estado_out    = {1'b0, state};
    jogada_out    = '0;
    leds_out      = '0;
    pontuacao_out = pont_q;
    if (state == ERRO) estado_out = 4'hE;
    if (state == EXECUCAO || state == FIM) begin
      estado_out = games.game_estado[4*idx +: 4];
      jogada_out = games.game_jogada[7*idx +: 7];
      leds_out   = games.game_leds[LED_W*idx +: LED_W];
    end
    if (state == EXECUCAO) pontuacao_out = score_sel;
  end

endmodule

// File: tb/tb_minigame_hub.sv
// tb/tb_minigame_hub.sv - self-checking bench for minigame_hub with a best-score reference model
module tb_minigame_hub;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int SC = 3;
  localparam int LW = 3;
  localparam int TO = 10;

  logic          clock = 1'b0;
  logic          reset, iniciar, abortar, dificuldade;
  logic [SW-1:0] minigame_sel;
  logic [SW-1:0] minigame_out;
  logic [3:0]    estado_out;
  logic [6:0]    jogada_out;
  logic [LW-1:0] leds_out;
  logic [SC-1:0] pontuacao_out, recorde_out;
  logic          novo_recorde, timeout_out;
  logic [2:0]    hub_estado;

  minigame_hub_if #(.N_GAMES(N), .SCORE_W(SC), .LED_W(LW)) bus ();

  minigame_hub #(.N_GAMES(N), .SEL_W(SW), .SCORE_W(SC), .LED_W(LW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
    .dificuldade(dificuldade), .minigame_sel(minigame_sel), .games(bus),
    .minigame_out(minigame_out), .estado_out(estado_out), .jogada_out(jogada_out),
    .leds_out(leds_out), .pontuacao_out(pontuacao_out), .recorde_out(recorde_out),
    .novo_recorde(novo_recorde), .timeout_out(timeout_out), .hub_estado(hub_estado)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int best [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic randomize_bus();
    bus.game_estado    = 12'($urandom);
    bus.game_jogada    = 21'($urandom);
    bus.game_leds      = 9'($urandom);
    bus.game_pontuacao = 9'($urandom);
  endtask

  task automatic check_mux(input int sel);
    chk("mux_estado", estado_out, bus.game_estado[4*sel +: 4]);
    chk("mux_jogada", jogada_out, bus.game_jogada[7*sel +: 7]);
    chk("mux_leds",   leds_out,   bus.game_leds[LW*sel +: LW]);
  endtask

  task automatic start_req(input int sel, input int dif);
    minigame_sel = SW'(sel);
    dificuldade  = dif[0];
    iniciar      = 1'b1;
    tick();
    chk("prep_state", hub_estado, 1);
    iniciar = 1'b0;
    tick();
  endtask

  task automatic session(input int sel, input int dif, input int s, input int extra);
    bit exp_novo;
    randomize_bus();
    bus.game_pronto = '0;
    start_req(sel, dif);
    chk("exec_state", hub_estado, 2);
    chk("jogar_pulse", bus.game_jogar, 1 << sel);
    chk("dif_latch", bus.game_dificuldade, dif);
    chk("sel_latch", minigame_out, sel);
    tick();
    chk("jogar_clear", bus.game_jogar, 0);
    bus.game_pontuacao[SC*sel +: SC] = SC'(s);
    for (int k = 0; k < extra; k++) begin
      bus.game_pronto = N'($urandom) & ~(N'(1) << sel);
      tick();
      chk("exec_hold", hub_estado, 2);
    end
    bus.game_pronto = N'(1) << sel;
    #1;
    chk("pont_live", pontuacao_out, s);
    check_mux(sel);
    tick();
    bus.game_pronto = '0;
    exp_novo = s > best[sel];
    if (exp_novo) best[sel] = s;
    chk("fim_state", hub_estado, 3);
    chk("fim_pont", pontuacao_out, s);
    chk("fim_novo", novo_recorde, exp_novo);
    chk("fim_recorde", recorde_out, best[sel]);
    chk("fim_tmo", timeout_out, 0);
    bus.game_pontuacao = ~bus.game_pontuacao;
    bus.game_estado    = 12'($urandom);
    #1;
    chk("fim_frozen", pontuacao_out, s);
    check_mux(sel);
  endtask

  initial begin
    int starts;
    reset = 1'b1; iniciar = 1'b0; abortar = 1'b0; dificuldade = 1'b0; minigame_sel = '0;
    bus.game_pronto = '0;
    randomize_bus();
    foreach (best[g]) best[g] = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_state", hub_estado, 0);
    chk("rst_jogar", bus.game_jogar, 0);
    chk("rst_estado", estado_out, 0);
    chk("rst_pont", pontuacao_out, 0);
    chk("rst_rec", recorde_out, 0);
    chk("rst_sel", minigame_out, 0);
    chk("rst_dif", bus.game_dificuldade, 0);
    chk("rst_flags", {novo_recorde, timeout_out}, 0);
    chk("rst_leds", {jogada_out, leds_out}, 0);
    reset = 1'b0;
    tick();

    // New best on game 1, then a lower replay that must not replace it.
    session(1, 1, 5, 2);
    session(1, 0, 3, 1);

    // Invalid selection goes to ERRO with no start pulse; recovery to game 0.
    start_req(3, 0);
    chk("erro_state", hub_estado, 4);
    chk("erro_estado", estado_out, 4'hE);
    chk("erro_jogar", bus.game_jogar, 0);
    chk("erro_mux", {jogada_out, leds_out}, 0);
    tick();
    chk("erro_hold", hub_estado, 4);
    session(0, 1, $urandom_range(1, 7), 0);

    // Timeout: FIM exactly TO cycles after entering EXECUCAO, best score untouched.
    bus.game_pronto = '0;
    start_req(2, 0);
    chk("to_enter", hub_estado, 2);
    for (int k = 1; k < TO; k++) tick();
    chk("to_before", hub_estado, 2);
    tick();
    chk("to_fim", hub_estado, 3);
    chk("to_flag", timeout_out, 1);
    chk("to_novo", novo_recorde, 0);
    chk("to_rec", recorde_out, best[2]);

    // Non-selected done ignored; abort wins over a simultaneous done.
    start_req(0, 0);
    bus.game_pronto = 3'b110;
    tick();
    chk("other_pronto", hub_estado, 2);
    abortar = 1'b1;
    bus.game_pronto = 3'b001;
    bus.game_pontuacao[0 +: SC] = 3'd7;
    tick();
    abortar = 1'b0;
    bus.game_pronto = '0;
    chk("abort_state", hub_estado, 0);
    chk("abort_flags", {novo_recorde, timeout_out}, 0);
    chk("abort_rec", recorde_out, best[0]);
    abortar = 1'b1;
    tick();
    abortar = 1'b0;
    chk("abort_idle", hub_estado, 0);

    repeat (10) session($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 5));

    // A level held high starts a single session only.
    minigame_sel = 2'd0;
    iniciar = 1'b1;
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (hub_estado == 3'd1) starts++;
    end
    iniciar = 1'b0;
    chk("held_starts", starts, 1);
    chk("held_state", hub_estado, 3);
    chk("held_tmo", timeout_out, 1);
    tick();

    // Asynchronous reset mid-session clears everything before the next edge.
    start_req(1, 1);
    chk("pre_rst_jogar", bus.game_jogar, 3'b010);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", hub_estado, 0);
    chk("arst_jogar", bus.game_jogar, 0);
    chk("arst_out", {minigame_out, estado_out, pontuacao_out, recorde_out}, 0);
    chk("arst_misc", {bus.game_dificuldade, novo_recorde, timeout_out, jogada_out, leds_out}, 0);
    #1;
    reset = 1'b0;
    foreach (best[g]) best[g] = 0;
    tick();
    session(1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
